// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: fetch and load/store bus between a CPU (master) and cpu_mem_responder (slave)
interface cpu_mem_responder_if;
    logic        i_pc_rd;
    logic [15:0] i_pc_addr;
    logic [15:0] o_pc_rddata;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_addr;
    logic [15:0] i_ldst_wrdata;
    logic [15:0] o_ldst_rddata;
    logic [15:0] o_leds;
    logic        o_err;
    modport master (
        output i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
        input  o_pc_rddata, o_ldst_rddata, o_leds, o_err
    );
    modport slave (
        input  i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
        output o_pc_rddata, o_ldst_rddata, o_leds, o_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: dual-port RAM plus MMIO window (cycle counter only with CPU_MEM_MMIO_TIMER_EN, LEDs, error count)
module cpu_mem_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input logic                clk,
    input logic                reset,
    cpu_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [15:0] ram [DEPTH];
    logic [15:0] pc_q, ld_q, mmio_q, leds, err_cnt, cycles, mmio_rd, pc_off, ld_off;
    logic        pc_zero, ld_ram, err, err_next, pc_mmio, pc_oob, ld_mmio, ld_oob, ld_en, ld_any;
    assign pc_off   = bus.i_pc_addr - MMIO_BASE;
    assign ld_off   = bus.i_ldst_addr - MMIO_BASE;
    assign pc_mmio  = bus.i_pc_addr >= MMIO_BASE && pc_off < 16'd8;
    assign ld_mmio  = bus.i_ldst_addr >= MMIO_BASE && ld_off < 16'd8;
    assign pc_oob   = !pc_mmio && {1'b0, bus.i_pc_addr[15:1]} >= 16'(DEPTH);
    assign ld_oob   = !ld_mmio && {1'b0, bus.i_ldst_addr[15:1]} >= 16'(DEPTH);
    assign ld_en    = bus.i_ldst_rd && !bus.i_ldst_wr;
    assign ld_any   = bus.i_ldst_rd || bus.i_ldst_wr;
    assign err_next = (bus.i_pc_rd && (bus.i_pc_addr[0] || pc_mmio || pc_oob))
                   || (ld_any && (bus.i_ldst_addr[0] || ld_oob))
                   || (bus.i_ldst_rd && bus.i_ldst_wr);
    assign mmio_rd  = ld_off[2:1] == 2'd0 ? cycles :
                      ld_off[2:1] == 2'd1 ? leds :
                      ld_off[2:1] == 2'd2 ? err_cnt : 16'h0000;
    // Plain read/write ports so the array maps onto block RAM; a fetch on the store edge sees old data.
    always_ff @(posedge clk) begin
        if (reset && bus.i_ldst_wr && !ld_mmio && !ld_oob)
            ram[bus.i_ldst_addr[AW:1]] <= bus.i_ldst_wrdata;
        if (reset && bus.i_pc_rd)
            pc_q <= ram[bus.i_pc_addr[AW:1]];
        if (reset && ld_en)
            ld_q <= ram[bus.i_ldst_addr[AW:1]];
    end
    // RAM read registers are never reset; these flags select a zero/MMIO value instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_zero <= 1'b1;
            ld_ram  <= 1'b0;
            mmio_q  <= '0;
            leds    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err     <= err_next;
            err_cnt <= err_cnt + 16'(err && err_cnt != 16'hFFFF);
            if (bus.i_pc_rd)
                pc_zero <= pc_mmio || pc_oob;
            if (ld_en) begin
                ld_ram <= !ld_mmio && !ld_oob;
                mmio_q <= ld_mmio ? mmio_rd : 16'h0000;
            end
            if (bus.i_ldst_wr && ld_mmio && ld_off[2:1] == 2'd1)
                leds <= bus.i_ldst_wrdata;
        end
    end
`ifdef CPU_MEM_MMIO_TIMER_EN
    always_ff @(posedge clk)
        cycles <= reset ? cycles + 16'd1 : 16'h0000;
`else
    assign cycles = 16'h0000;
`endif
    assign bus.o_pc_rddata   = pc_zero ? 16'h0000 : pc_q;
    assign bus.o_ldst_rddata = ld_ram ? ld_q : mmio_q;
    assign bus.o_leds        = leds;
    assign bus.o_err         = err;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed plus randomized traffic checked against a queue-fed reference model
module tb_cpu_mem_responder;
    localparam int          DEPTH     = 4096;
    localparam logic [15:0] MMIO_BASE = 16'hFF00;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ld;
        logic [15:0] leds;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    cpu_mem_responder_if bus();
    cpu_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          passed = 0;
    logic [15:0] mem [int];
    logic [15:0] m_pc = 0, m_ld = 0, m_leds = 0, m_errcnt = 0, m_cyc = 0;
    logic        m_err = 0;
    function automatic bit in_win(logic [15:0] a);
        return int'(a) >= int'(MMIO_BASE) && int'(a) < int'(MMIO_BASE) + 8;
    endfunction
    function automatic bit oob(logic [15:0] a);
        return !in_win(a) && int'(a) / 2 >= DEPTH;
    endfunction
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    task automatic step(input logic rst_n, input logic prd, input logic [15:0] pa,
                        input logic lrd, input logic lwr, input logic [15:0] la, input logic [15:0] wd);
        bit   ev;
        int   off;
        @(negedge clk);
        reset             = rst_n;
        bus.i_pc_rd       = prd;
        bus.i_pc_addr     = pa;
        bus.i_ldst_rd     = lrd;
        bus.i_ldst_wr     = lwr;
        bus.i_ldst_addr   = la;
        bus.i_ldst_wrdata = wd;
        if (!rst_n) begin
            m_pc = 0; m_ld = 0; m_leds = 0; m_errcnt = 0; m_cyc = 0; m_err = 0;
        end else begin
            ev = (prd && (pa[0] || in_win(pa) || oob(pa))) || ((lrd || lwr) && (la[0] || oob(la))) || (lrd && lwr);
            if (prd) m_pc = (in_win(pa) || oob(pa)) ? 16'h0000 : mem[int'(pa) / 2];
            if (lrd && !lwr) begin
                off = (int'(la) - int'(MMIO_BASE)) / 2;
                if (in_win(la)) m_ld = off == 0 ? m_cyc : off == 1 ? m_leds : off == 2 ? m_errcnt : 16'h0000;
                else if (oob(la)) m_ld = 16'h0000;
                else m_ld = mem[int'(la) / 2];
            end
            if (lwr) begin
                if (in_win(la)) begin
                    if ((int'(la) - int'(MMIO_BASE)) / 2 == 1) m_leds = wd;
                end else if (!oob(la)) mem[int'(la) / 2] = wd;
            end
            if (m_err && m_errcnt != 16'hFFFF) m_errcnt++;
            m_err = ev;
`ifdef CPU_MEM_MMIO_TIMER_EN
            m_cyc++;
`endif
        end
        q.push_back('{pc: m_pc, ld: m_ld, leds: m_leds, err: m_err});
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc_rddata", bus.o_pc_rddata, e.pc);
            chk("ldst_rddata", bus.o_ldst_rddata, e.ld);
            chk("leds", bus.o_leds, e.leds);
            chk("err", {15'd0, bus.o_err}, {15'd0, e.err});
        end
    end
    function automatic logic [15:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5) return 16'($urandom_range(0, 63));
        if (k <= 7) return MMIO_BASE + 16'($urandom_range(0, 7));
        if (k == 8) return 16'h2000 + 16'($urandom_range(0, 16'hDEFF));
        return 16'hFF08 + 16'($urandom_range(0, 16'h00F7));
    endfunction
    initial begin
        int          k;
        logic        rd, wr, prd, rn;
        bus.i_pc_rd = 0; bus.i_pc_addr = 0; bus.i_ldst_rd = 0; bus.i_ldst_wr = 0;
        bus.i_ldst_addr = 0; bus.i_ldst_wrdata = 0;
        step(0, 1, 16'h0000, 0, 1, 16'hFF02, 16'h1111);
        step(0, 0, 16'h0000, 0, 1, 16'h0010, 16'h2222);
        for (int w = 0; w < 32; w++)
            step(1, 0, 0, 0, 1, 16'(w * 2), w == 16 ? 16'hAAAA : 16'($urandom));
        step(1, 0, 0, 0, 1, 16'h0010, 16'hBEEF);
        step(1, 0, 0, 1, 0, 16'h0010, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 16'h0020, 0, 1, 16'h0020, 16'h1234);
        step(1, 1, 16'h0020, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 16'h0010, 16'h5A5A);
        step(1, 0, 0, 1, 0, 16'h0011, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, MMIO_BASE + 16'd4, 0);
        step(1, 0, 0, 0, 1, MMIO_BASE + 16'd2, 16'h00FF);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, MMIO_BASE, 0);
        step(1, 0, 0, 1, 1, 16'h0030, 16'h0F0F);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 16'h0030, 0);
        for (int i = 0; i < 2000; i++) begin
            k   = $urandom_range(0, 99);
            rd  = k < 40 || (k >= 70 && k < 75);
            wr  = k >= 40 && k < 75;
            prd = $urandom_range(0, 9) < 7;
            rn  = $urandom_range(0, 99) != 0;
            step(rn, prd, rand_addr(), rd, wr, rand_addr(), 16'($urandom));
        end
        @(posedge clk);
        #2;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
